// File: rtl/i2c_txn_scheduler_pkg.sv
// Shared types and constants for the I2C transaction scheduler.
// FSM state encoding, status codes and the round-robin wrap helper.
package i2c_txn_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_BADLEN  = 2'b11
  } status_t;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NB_W   = 8;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer,
// pointer advances to owner+1 on an update pulse.
module rr_arbiter
  import i2c_txn_scheduler_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_enable,
  input  logic          i_update,
  input  logic [IW-1:0] i_owner,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_winner
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IW'((32'(r_ptr) + k) % N);
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_winner        = w_idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= IW'(rr_next(32'(i_owner), N));
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares one i2c_master between N_REQ requesters: round-robin grant,
// ena/busy sequencing, byte-count termination and a per-transaction watchdog.
module i2c_txn_scheduler
  import i2c_txn_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [7*N_REQ-1:0]    req_addr,
  input  logic [N_REQ-1:0]      req_rw,
  input  logic [32*N_REQ-1:0]   req_wdata,
  input  logic [8*N_REQ-1:0]    req_nbytes,
  input  logic [N_REQ-1:0]      req_ronly,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [31:0]           rdata,
  output logic [1:0]            status,
  output logic                  m_ena,
  output logic [6:0]            m_addr,
  output logic                  m_rw,
  output logic [31:0]           m_data_wr,
  output logic [7:0]            m_nbytes,
  output logic                  m_read_only,
  input  logic                  m_busy,
  input  logic [7:0]            m_byte_counter,
  input  logic [31:0]           m_data_rd,
  input  logic                  m_ack_error
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t            r_state;
  logic [IW-1:0]     r_owner;
  logic [TO_W-1:0]   r_wd;

  logic [N_REQ-1:0]  w_arb_grant;
  logic [IW-1:0]     w_arb_winner;
  int unsigned       w_sel;
  logic              w_counting;
  logic              w_timeout;

  assign w_sel      = 32'(w_arb_winner);
  assign w_counting = (r_state == S_START) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_timeout  = w_counting && (r_wd == TO_W'(TIMEOUT - 1));

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .i_req    (req),
    .i_enable (r_state == S_IDLE),
    .i_update (r_state == S_DONE),
    .i_owner  (r_owner),
    .o_grant  (w_arb_grant),
    .o_winner (w_arb_winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_wd        <= '0;
      grant       <= '0;
      done        <= '0;
      rdata       <= '0;
      status      <= ST_OK;
      m_ena       <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_data_wr   <= '0;
      m_nbytes    <= '0;
      m_read_only <= 1'b0;
    end else begin
      done <= '0;
      if (w_counting) r_wd <= r_wd + 1'b1;
      // Watchdog outranks every in-flight state, so it also outranks NACK.
      if (w_timeout) begin
        m_ena          <= 1'b0;
        status         <= ST_TIMEOUT;
        done[r_owner]  <= 1'b1;
        r_state        <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (|w_arb_grant) begin
              grant       <= w_arb_grant;
              r_owner     <= w_arb_winner;
              m_addr      <= req_addr[w_sel*7 +: 7];
              m_rw        <= req_rw[w_arb_winner];
              m_data_wr   <= req_wdata[w_sel*32 +: 32];
              m_nbytes    <= req_nbytes[w_sel*8 +: 8];
              m_read_only <= req_ronly[w_arb_winner];
              r_wd        <= '0;
              r_state     <= S_LATCH;
            end
          end
          S_LATCH: begin
            r_wd <= '0;
            if (m_nbytes == '0) begin
              status        <= ST_BADLEN;
              done[r_owner] <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              m_ena   <= 1'b1;
              r_state <= S_START;
            end
          end
          S_START: begin
            if (m_busy) r_state <= S_RUN;
          end
          S_RUN: begin
            if (m_byte_counter >= m_nbytes) begin
              m_ena   <= 1'b0;
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (!m_busy) begin
              rdata         <= m_data_rd;
              status        <= m_ack_error ? ST_NACK : ST_OK;
              done[r_owner] <= 1'b1;
              r_state       <= S_DONE;
            end
          end
          S_DONE: begin
            grant   <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a small i2c_master bus model.
module tb_i2c_txn_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [27:0]  req_addr;
  logic [3:0]   req_rw;
  logic [127:0] req_wdata;
  logic [31:0]  req_nbytes;
  logic [3:0]   req_ronly;
  logic [3:0]   grant, done;
  logic [31:0]  rdata;
  logic [1:0]   status;
  logic         m_ena, m_rw, m_read_only;
  logic [6:0]   m_addr;
  logic [31:0]  m_data_wr;
  logic [7:0]   m_nbytes;
  logic         m_busy;
  logic [7:0]   m_byte_counter;
  logic [31:0]  m_data_rd;
  logic         m_ack_error;

  logic         mdl_hang, mdl_nack;
  logic [31:0]  mdl_rdata;
  logic [1:0]   mdl_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  i2c_txn_scheduler #(.N_REQ(4), .TO_W(20), .TIMEOUT(50)) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_nbytes(req_nbytes), .req_ronly(req_ronly),
    .grant(grant), .done(done), .rdata(rdata), .status(status),
    .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
    .m_nbytes(m_nbytes), .m_read_only(m_read_only),
    .m_busy(m_busy), .m_byte_counter(m_byte_counter),
    .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
  );

  // Bus model: busy rises 2 cycles after ena, one byte per 3 busy cycles,
  // busy falls one cycle after ena drops; ack_error held from transfer start.
  assign m_data_rd = mdl_rdata;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_byte_counter <= 8'd0; mdl_cnt <= 2'd0; m_ack_error <= 1'b0;
    end else if (!m_busy) begin
      m_byte_counter <= 8'd0;
      if (m_ena) begin
        mdl_cnt <= mdl_cnt + 2'd1;
        if (mdl_cnt == 2'd1) begin
          m_busy <= 1'b1; mdl_cnt <= 2'd0; m_ack_error <= mdl_nack;
        end
      end else mdl_cnt <= 2'd0;
    end else if (!mdl_hang) begin
      if (m_ena) begin
        mdl_cnt <= mdl_cnt + 2'd1;
        if (mdl_cnt == 2'd2) begin
          mdl_cnt <= 2'd0; m_byte_counter <= m_byte_counter + 8'd1;
        end
      end else begin
        m_busy <= 1'b0; mdl_cnt <= 2'd0;
      end
    end
  end

  task automatic set_req(input int i, input logic [6:0] a, input logic rw,
                         input logic [31:0] wd, input logic [7:0] nb, input logic ro);
    req_addr[i*7 +: 7]    = a;
    req_rw[i]             = rw;
    req_wdata[i*32 +: 32] = wd;
    req_nbytes[i*8 +: 8]  = nb;
    req_ronly[i]          = ro;
  endtask

  task automatic wait_grant(input int lim, output bit ok, output int cyc);
    ok = 0; cyc = 0;
    while (!ok && cyc < lim) begin
      @(negedge clock); cyc++;
      if (grant !== 4'b0) ok = 1;
    end
  endtask

  task automatic wait_done(input int lim, output bit ok, output int cyc, output int fall_cyc,
                           output int ena_cnt, output int low_tail);
    logic pb;
    pb = m_busy; ok = 0; cyc = 0; fall_cyc = -1; ena_cnt = 0; low_tail = 0;
    while (!ok && cyc < lim) begin
      @(negedge clock); cyc++;
      if (m_ena) begin ena_cnt++; low_tail = 0; end else low_tail++;
      if (pb && !m_busy) fall_cyc = cyc;
      pb = m_busy;
      if (done !== 4'b0) ok = 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
    n_vec++; if (m_ena !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", m_ena); end
    n_vec++; if (rdata !== 32'h0 || m_data_wr !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got rdata=%h wr=%h want 0", rdata, m_data_wr); end
    n_vec++; if (status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b want 00", status); end
    n_vec++; if ({m_addr, m_nbytes, m_rw, m_read_only} !== 17'h0) begin
      n_err++; $display("FAIL reset_fields: got addr=%h nb=%h rw=%b ro=%b want 0", m_addr, m_nbytes, m_rw, m_read_only); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL idle_no_req: grant=%b want 0000", grant); end
  endtask

  task automatic test_single_write;
    bit ok; int cyc, fall, enac, tail;
    set_req(2, 7'h48, 1'b0, 32'h0000_00A5, 8'd1, 1'b0);
    req = 4'b0100;
    @(negedge clock);
    n_vec++; if (grant !== 4'b0100 || m_ena !== 1'b0) begin
      n_err++; $display("FAIL wr_latch: grant=%b ena=%b want 0100/0", grant, m_ena); end
    n_vec++; if (m_addr !== 7'h48 || m_data_wr !== 32'hA5 || m_nbytes !== 8'd1 || m_rw !== 1'b0) begin
      n_err++; $display("FAIL wr_fields: addr=%h wr=%h nb=%h rw=%b want 48/a5/01/0", m_addr, m_data_wr, m_nbytes, m_rw); end
    @(negedge clock);
    n_vec++; if (m_ena !== 1'b1) begin n_err++; $display("FAIL wr_start_ena: got %b want 1", m_ena); end
    wait_done(40, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || done !== 4'b0100 || status !== 2'b00) begin
      n_err++; $display("FAIL wr_done: ok=%0d done=%b status=%b want 0100/00", ok, done, status); end
    n_vec++; if (enac !== 5 || fall !== cyc - 1) begin
      n_err++; $display("FAIL wr_timing: ena_cycles=%0d want 5, busy_fall=%0d want %0d", enac, fall, cyc - 1); end
    n_vec++; if (m_addr !== 7'h48) begin n_err++; $display("FAIL wr_stable: addr=%h want 48", m_addr); end
    req = 4'b0000;
    @(negedge clock);
    n_vec++; if (done !== 4'b0 || grant !== 4'b0) begin
      n_err++; $display("FAIL wr_after: done=%b grant=%b want 0000/0000", done, grant); end
  endtask

  task automatic test_read;
    bit ok; int cyc, fall, enac, tail;
    set_req(0, 7'h50, 1'b1, 32'h0, 8'd4, 1'b0);
    mdl_rdata = 32'hDEAD_BEEF;
    req = 4'b0001;
    wait_grant(10, ok, cyc);
    n_vec++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL rd_grant: got %b want 0001", grant); end
    wait_done(80, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || done !== 4'b0001 || rdata !== 32'hDEAD_BEEF || status !== 2'b00) begin
      n_err++; $display("FAIL rd_done: done=%b rdata=%h status=%b want 0001/deadbeef/00", done, rdata, status); end
    req = 4'b0000;
    mdl_rdata = 32'h0;
    repeat (2) @(negedge clock);
    n_vec++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_hold: rdata=%h want deadbeef", rdata); end
  endtask

  task automatic test_contention;
    bit ok; int cyc, fall, enac, tail, gap, min_gap;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 7'h10 + 7'(i), 1'b0, 32'h100 + 32'(i), 8'd1, 1'b0);
    req = 4'b1111;
    min_gap = 1000; tail = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(10, ok, cyc);
      gap = tail + cyc;
      if (k > 0 && gap < min_gap) min_gap = gap;
      n_vec++; if (!ok || grant !== (4'b0001 << exp_order[k])) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want one-hot %0d", k, grant, exp_order[k]); end
      wait_done(40, ok, cyc, fall, enac, tail);
      n_vec++; if (!ok || done !== (4'b0001 << exp_order[k])) begin
        n_err++; $display("FAIL rr_done%0d: got %b want one-hot %0d", k, done, exp_order[k]); end
      if (k == 4) req = 4'b0000;
    end
    n_vec++; if (min_gap < 3 || min_gap == 1000) begin
      n_err++; $display("FAIL rr_gap: min ena-low gap=%0d want >=3", min_gap); end
    @(negedge clock);
  endtask

  task automatic test_nack;
    bit ok; int cyc, fall, enac, tail;
    set_req(1, 7'h22, 1'b0, 32'h55, 8'd1, 1'b0);
    set_req(2, 7'h23, 1'b1, 32'h0, 8'd2, 1'b1);
    mdl_nack = 1'b1; mdl_rdata = 32'h1234_5678;
    req = 4'b0110;
    wait_grant(10, ok, cyc);
    n_vec++; if (!ok || grant !== 4'b0010) begin n_err++; $display("FAIL nack_grant: got %b want 0010", grant); end
    wait_done(40, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || done !== 4'b0010 || status !== 2'b01) begin
      n_err++; $display("FAIL nack_status: done=%b status=%b want 0010/01", done, status); end
    req[1] = 1'b0; mdl_nack = 1'b0;
    wait_grant(10, ok, cyc);
    n_vec++; if (!ok || grant !== 4'b0100 || m_read_only !== 1'b1) begin
      n_err++; $display("FAIL nack_next: grant=%b ro=%b want 0100/1", grant, m_read_only); end
    wait_done(60, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || done !== 4'b0100 || status !== 2'b00) begin
      n_err++; $display("FAIL nack_recover: done=%b status=%b want 0100/00", done, status); end
    req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_hang;
    bit ok; int cyc, fall, enac, tail;
    set_req(3, 7'h33, 1'b1, 32'h0, 8'd2, 1'b0);
    mdl_hang = 1'b1; mdl_rdata = 32'hCAFE_F00D;
    req = 4'b1000;
    wait_grant(10, ok, cyc);
    n_vec++; if (!ok || grant !== 4'b1000) begin n_err++; $display("FAIL hang_grant: got %b want 1000", grant); end
    @(negedge clock);
    wait_done(100, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || 1 + enac !== 50 || m_ena !== 1'b0) begin
      n_err++; $display("FAIL hang_ena: ok=%0d ena_cycles=%0d want 50, ena=%b", ok, 1 + enac, m_ena); end
    n_vec++; if (done !== 4'b1000 || status !== 2'b10 || rdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL hang_status: done=%b status=%b rdata=%h want 1000/10/12345678", done, status, rdata); end
    req = 4'b0000; mdl_hang = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_badlen;
    bit ok; int cyc, fall, enac, tail;
    set_req(1, 7'h11, 1'b0, 32'hFF, 8'd0, 1'b0);
    req = 4'b0010;
    wait_grant(10, ok, cyc);
    n_vec++; if (!ok || grant !== 4'b0010 || m_ena !== 1'b0) begin
      n_err++; $display("FAIL badlen_grant: grant=%b ena=%b want 0010/0", grant, m_ena); end
    wait_done(10, ok, cyc, fall, enac, tail);
    n_vec++; if (!ok || done !== 4'b0010 || status !== 2'b11 || enac !== 0) begin
      n_err++; $display("FAIL badlen_done: done=%b status=%b ena_cycles=%0d want 0010/11/0", done, status, enac); end
    req = 4'b0000;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid;
    bit ok; int cyc; bit saw_done;
    set_req(0, 7'h40, 1'b1, 32'h0, 8'd4, 1'b0);
    req = 4'b0001;
    wait_grant(10, ok, cyc);
    cyc = 0;
    while (!m_busy && cyc < 10) begin @(negedge clock); cyc++; end
    @(negedge clock);
    n_vec++; if (m_busy !== 1'b1 || m_ena !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_run: busy=%b ena=%b want 1/1", m_busy, m_ena); end
    reset = 1'b1;
    #1;
    n_vec++; if (m_ena !== 1'b0 || grant !== 4'b0) begin
      n_err++; $display("FAIL rst_mid_drop: ena=%b grant=%b want 0/0000", m_ena, grant); end
    req = 4'b0000;
    saw_done = 0;
    repeat (3) begin @(negedge clock); if (done !== 4'b0) saw_done = 1; end
    reset = 1'b0;
    repeat (5) begin @(negedge clock); if (done !== 4'b0 || grant !== 4'b0) saw_done = 1; end
    n_vec++; if (saw_done) begin n_err++; $display("FAIL rst_mid_nodone: got activity=1 want 0"); end
  endtask

  initial begin
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0; req_nbytes = '0; req_ronly = '0;
    mdl_hang = 1'b0; mdl_nack = 1'b0; mdl_rdata = '0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_nack();
    test_hang();
    test_badlen();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

endmodule
